digital_axis_ramp: RTL and testbench



---
 rtl/axis_ramp_pkg.sv | 22 ++
 rtl/axis_ramp_chan.sv | 103 ++++++++++
 rtl/digital_axis_ramp.sv | 77 +++++++
 tb/tb_digital_axis_ramp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_ramp_pkg.sv
// Shared definitions for the digital axis ramp: channel modes and the clamp helper.
package axis_ramp_pkg;

  // Per-channel operating mode; encoding 2'd3 is not listed and behaves as HOLD.
  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_SPRING = 2'd1,
    MODE_PASS   = 2'd2
  } axis_mode_e;

  // Upper clamp done on 32-bit operands so callers can widen first and never wrap.
  function automatic logic [31:0] clamp_hi(input logic [31:0] v, input logic [31:0] hi);
    logic [31:0] r;
    if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_ramp_chan.sv
// One axis channel: HOLD / SPRING / PASS update of a clamped accumulator.
// The accumulator is value_out itself, so mode changes never jump.
module axis_ramp_chan
  import axis_ramp_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP    = 1,
  parameter int MAX_VAL = (1 << WIDTH) - 2,
  parameter int CENTER  = 1 << (WIDTH - 1)
) (
  input  logic             clk_50,
  input  logic             RESET_L,
  input  logic             tick,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] analog_in,
  output logic [WIDTH-1:0] value_out,
  output logic             at_min,
  output logic             at_max
);

  // One guard bit above WIDTH keeps cur+STEP from wrapping before the clamp.
  localparam int W1 = WIDTH + 1;
  localparam logic [W1-1:0] MAX_X  = W1'(MAX_VAL);
  localparam logic [W1-1:0] CEN_X  = W1'(CENTER);
  localparam logic [W1-1:0] STEP_X = W1'(STEP);

  logic [WIDTH-1:0] value_r;
  logic             at_min_r;
  logic             at_max_r;
  logic [W1-1:0]    cur_s;
  logic [W1-1:0]    pass_s;
  logic [W1-1:0]    up_s;
  logic [W1-1:0]    down_s;
  logic [W1-1:0]    spring_s;
  logic [W1-1:0]    next_s;

  // Candidate values for each kind of move, all saturating.
  always_comb begin
    cur_s  = {1'b0, value_r};
    pass_s = W1'(clamp_hi(32'(analog_in), 32'(MAX_VAL)));
    up_s   = W1'(clamp_hi(32'(cur_s + STEP_X), 32'(MAX_VAL)));
    if (cur_s >= STEP_X) begin
      down_s = cur_s - STEP_X;
    end else begin
      down_s = {W1{1'b0}};
    end
    // Spring return lands exactly on CENTER when closer than one step.
    if (cur_s > CEN_X) begin
      spring_s = ((cur_s - CEN_X) > STEP_X) ? (cur_s - STEP_X) : CEN_X;
    end else if (cur_s < CEN_X) begin
      spring_s = ((CEN_X - cur_s) > STEP_X) ? (cur_s + STEP_X) : CEN_X;
    end else begin
      spring_s = CEN_X;
    end
  end

  // Next value selection: clear, then PASS tracking, then tick-gated ramping.
  always_comb begin
    next_s = cur_s;
    if (clear) begin
      case (mode)
        MODE_SPRING: next_s = CEN_X;
        MODE_PASS:   next_s = pass_s;
        default:     next_s = {W1{1'b0}};
      endcase
    end else if (mode == MODE_PASS) begin
      next_s = pass_s;
    end else if (tick) begin
      if (inc && !dec) begin
        next_s = up_s;
      end else if (dec && !inc) begin
        next_s = down_s;
      end else if (mode == MODE_SPRING) begin
        next_s = spring_s;
      end else begin
        next_s = cur_s;
      end
    end else begin
      next_s = cur_s;
    end
  end

  // Value and limit flags registered together from the same next value.
  always_ff @(posedge clk_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      value_r  <= {WIDTH{1'b0}};
      at_min_r <= 1'b1;
      at_max_r <= 1'b0;
    end else begin
      value_r  <= next_s[WIDTH-1:0];
      at_min_r <= (next_s == {W1{1'b0}});
      at_max_r <= (next_s == MAX_X);
    end
  end

  assign value_out = value_r;
  assign at_min    = at_min_r;
  assign at_max    = at_max_r;

endmodule

// File: rtl/digital_axis_ramp.sv
// Multi-channel axis ramp: shared tick divider feeding CHANNELS independent channels.
module digital_axis_ramp
  import axis_ramp_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 196850,
  parameter int STEP     = 1,
  parameter int MAX_VAL  = (1 << WIDTH) - 2,
  parameter int CENTER   = 1 << (WIDTH - 1)
) (
  input  logic                      clk_50,
  input  logic                      RESET_L,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [WIDTH*CHANNELS-1:0] analog_in,
  input  logic                      clear,
  output logic [WIDTH*CHANNELS-1:0] value_out,
  output logic [CHANNELS-1:0]       at_min,
  output logic [CHANNELS-1:0]       at_max,
  output logic                      tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             tick_r;

  // Divider next count: clear restarts the period, otherwise wrap at the last count.
  always_comb begin
    if (clear) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Counter and a tick flag that is high exactly while the count sits at its last value.
  always_ff @(posedge clk_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      cnt_r  <= {CNT_W{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= (cnt_next_s == CNT_LAST);
    end
  end

  assign tick = tick_r;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    axis_ramp_chan #(
      .WIDTH  (WIDTH),
      .STEP   (STEP),
      .MAX_VAL(MAX_VAL),
      .CENTER (CENTER)
    ) u_chan (
      .clk_50   (clk_50),
      .RESET_L  (RESET_L),
      .tick     (tick_r),
      .clear    (clear),
      .inc      (inc[c]),
      .dec      (dec[c]),
      .mode     (mode[2*c +: 2]),
      .analog_in(analog_in[WIDTH*c +: WIDTH]),
      .value_out(value_out[WIDTH*c +: WIDTH]),
      .at_min   (at_min[c]),
      .at_max   (at_max[c])
    );
  end

endmodule

// File: tb/tb_digital_axis_ramp.sv
// Self-checking bench for digital_axis_ramp: behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_digital_axis_ramp;

  localparam int CH   = 2;
  localparam int W    = 8;
  localparam int TD   = 4;
  localparam int STP  = 1;
  localparam int MAXV = 254;
  localparam int CEN  = 128;

  logic          clk_50 = 1'b0;
  logic          RESET_L = 1'b1;
  logic [1:0]    inc = 2'b00;
  logic [1:0]    dec = 2'b00;
  logic [3:0]    mode = 4'h0;
  logic [15:0]   analog_in = 16'h0000;
  logic          clear = 1'b0;
  logic [15:0]   value_out;
  logic [1:0]    at_min;
  logic [1:0]    at_max;
  logic          tick;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int mcnt = 0;
  int mval [CH] = '{0, 0};

  digital_axis_ramp #(
    .CHANNELS(CH), .WIDTH(W), .TICK_DIV(TD), .STEP(STP), .MAX_VAL(MAXV), .CENTER(CEN)
  ) dut (
    .clk_50(clk_50), .RESET_L(RESET_L), .inc(inc), .dec(dec), .mode(mode),
    .analog_in(analog_in), .clear(clear), .value_out(value_out),
    .at_min(at_min), .at_max(at_max), .tick(tick)
  );

  always #5 clk_50 = ~clk_50;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference rule for one channel, straight from the mode descriptions.
  function automatic int model_next(input int v, input int m, input bit i, input bit d,
                                    input int a, input bit tk, input bit clr);
    int lim;
    lim = (a > MAXV) ? MAXV : a;
    if (clr) return (m == 1) ? CEN : ((m == 2) ? lim : 0);
    if (m == 2) return lim;
    if (!tk) return v;
    if (i && !d) return (v + STP > MAXV) ? MAXV : v + STP;
    if (d && !i) return (v - STP < 0) ? 0 : v - STP;
    if (m == 1) begin
      if (v > CEN) return (v - CEN > STP) ? v - STP : CEN;
      if (v < CEN) return (CEN - v > STP) ? v + STP : CEN;
    end
    return v;
  endfunction

  // Model state advance.
  always @(posedge clk_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      mcnt <= 0;
      for (int c = 0; c < CH; c++) mval[c] <= 0;
    end else begin
      for (int c = 0; c < CH; c++)
        mval[c] <= model_next(mval[c], int'(mode[2*c +: 2]), inc[c], dec[c],
                              int'(analog_in[W*c +: W]), (mcnt == TD - 1), clear);
      if (clear || mcnt == TD - 1) mcnt <= 0;
      else mcnt <= mcnt + 1;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk_50) begin
    if (chk_en) begin
      for (int c = 0; c < CH; c++) begin
        check($sformatf("model_value_ch%0d", c), int'(value_out[W*c +: W]), mval[c]);
        check($sformatf("model_at_min_ch%0d", c), int'(at_min[c]), (mval[c] == 0) ? 1 : 0);
        check($sformatf("model_at_max_ch%0d", c), int'(at_max[c]), (mval[c] == MAXV) ? 1 : 0);
      end
      check("model_tick", int'(tick), (mcnt == TD - 1) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #2;
    end
  endtask

  task automatic set_ch(input int c, input int m, input bit i, input bit d, input int a);
    mode[2*c +: 2]      = 2'(m);
    inc[c]              = i;
    dec[c]              = d;
    analog_in[W*c +: W] = 8'(a);
  endtask

  task automatic cycles_to_tick(output int k);
    k = 0;
    while (tick !== 1'b1 && k < 3 * TD) begin
      cyc(1);
      k++;
    end
  endtask

  task automatic wait_tick_then(input string name);
    int k;
    cycles_to_tick(k);
    check({name, "_tick_seen"}, int'(tick), 1);
    cyc(1);
  endtask

  initial begin
    int k;
    int exp_dec [5] = '{2, 1, 0, 0, 0};
    #1 RESET_L = 1'b0;
    chk_en = 1'b1;
    cyc(3);
    check("rst_value", int'(value_out), 0);
    check("rst_at_min", int'(at_min), 3);
    check("rst_at_max", int'(at_max), 0);
    check("rst_tick", int'(tick), 0);
    RESET_L = 1'b1;

    // HOLD ramp up to the clamp
    set_ch(0, 0, 1'b1, 1'b0, 0);
    cyc(1100);
    check("hold_inc_value", int'(value_out[7:0]), 254);
    check("hold_inc_at_max", int'(at_max[0]), 1);
    check("hold_inc_ch1_idle", int'(value_out[15:8]), 0);

    // HOLD ramp down from 3 with no wrap
    set_ch(0, 2, 1'b0, 1'b0, 3);
    cyc(1);
    check("pass_3", int'(value_out[7:0]), 3);
    set_ch(0, 0, 1'b0, 1'b1, 3);
    for (int i = 0; i < 5; i++) begin
      wait_tick_then("dec");
      check($sformatf("dec_step%0d", i), int'(value_out[7:0]), exp_dec[i]);
    end
    check("dec_at_min", int'(at_min[0]), 1);

    // SPRING return from above and from below with both requests
    set_ch(0, 2, 1'b0, 1'b0, 250);
    cyc(1);
    set_ch(0, 1, 1'b0, 1'b0, 250);
    wait_tick_then("spring_hi");
    check("spring_hi_first", int'(value_out[7:0]), 249);
    cyc(4 * 130);
    check("spring_hi_rest", int'(value_out[7:0]), 128);
    set_ch(0, 2, 1'b0, 1'b0, 10);
    cyc(1);
    set_ch(0, 1, 1'b1, 1'b1, 10);
    wait_tick_then("spring_lo");
    check("spring_lo_first", int'(value_out[7:0]), 11);
    cyc(4 * 125);
    check("spring_lo_rest", int'(value_out[7:0]), 128);

    // PASS clamp and bumpless hand-over
    set_ch(0, 2, 1'b0, 1'b0, 255);
    cyc(1);
    check("pass_255", int'(value_out[7:0]), 254);
    check("pass_255_at_max", int'(at_max[0]), 1);
    set_ch(0, 0, 1'b1, 1'b0, 255);
    wait_tick_then("bump_inc");
    check("bump_inc", int'(value_out[7:0]), 254);
    set_ch(0, 2, 1'b0, 1'b0, 100);
    cyc(1);
    check("pass_100", int'(value_out[7:0]), 100);
    set_ch(0, 0, 1'b0, 1'b1, 100);
    wait_tick_then("bump_dec");
    check("bump_dec", int'(value_out[7:0]), 99);

    // clear in a tick cycle
    set_ch(0, 2, 1'b0, 1'b0, 200);
    set_ch(1, 2, 1'b0, 1'b0, 50);
    cyc(1);
    cycles_to_tick(k);
    check("clear_in_tick", int'(tick), 1);
    set_ch(0, 1, 1'b0, 1'b0, 200);
    set_ch(1, 0, 1'b0, 1'b0, 50);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clear_ch0", int'(value_out[7:0]), 128);
    check("clear_ch1", int'(value_out[15:8]), 0);
    cycles_to_tick(k);
    check("clear_tick_gap", k, 3);

    // reset mid-ramp
    set_ch(0, 2, 1'b0, 1'b0, 77);
    cyc(1);
    check("pre_rst_77", int'(value_out[7:0]), 77);
    set_ch(0, 0, 1'b1, 1'b0, 77);
    cyc(1);
    #1 RESET_L = 1'b0;
    #1;
    check("midrst_value", int'(value_out), 0);
    check("midrst_at_min", int'(at_min), 3);
    check("midrst_tick", int'(tick), 0);
    cyc(1);
    RESET_L = 1'b1;
    cycles_to_tick(k);
    check("midrst_tick_gap", k, 3);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 39) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) begin
          inc[c] = 1'($urandom_range(0, 1));
          dec[c] = 1'($urandom_range(0, 1));
        end
        analog_in[W*c +: W] = 8'($urandom);
      end
      clear = ($urandom_range(0, 99) == 0);
      if (!RESET_L) RESET_L = 1'b1;
      else if ($urandom_range(0, 599) == 0) RESET_L = 1'b0;
      cyc(1);
    end
    clear = 1'b0;
    RESET_L = 1'b1;
    cyc(2);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
